// File: rtl/sad_accum.sv
// sad_accum: sum of absolute differences over a window of WIN_LEN valid
// samples, presented on a one-entry valid/ready output slot. The upstream
// source cannot be stalled, so a result that finds the slot still occupied
// is dropped and the sticky ovfErr flag is raised.
// Optional feature macro SAD_ACCUM_PEAK_EN adds peakOut, the largest |dIn|
// seen in the window, which is loaded and held alongside sadOut.
module sad_accum #(
    parameter int DIN_W   = 5,
    parameter int WIN_LEN = 8,
    parameter int ACC_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DIN_W-1:0] dIn,
    input  logic                    dInValid,
    input  logic                    clr,
    output logic [ACC_W-1:0]        sadOut,
    output logic                    sadValid,
    input  logic                    sadReady,
    output logic                    ovfErr
`ifdef SAD_ACCUM_PEAK_EN
    ,
    output logic [DIN_W-1:0]        peakOut
`endif
);

    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DIN_W-1:0] MAG_ONE = DIN_W'(1);

    typedef enum logic {
        EMPTY,
        FULL
    } slot_t;

    slot_t            slot;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;
    logic [DIN_W-1:0] mag;
    logic             handshake;
    logic             complete;

`ifdef SAD_ACCUM_PEAK_EN
    logic [DIN_W-1:0] peak;
    logic [DIN_W-1:0] peak_max;
`endif

    // Unsigned magnitude of the sample; the most-negative code maps to
    // 2^(DIN_W-1), which still fits in DIN_W unsigned bits.
    always_comb begin
        mag       = dIn[DIN_W-1] ? (~dIn + MAG_ONE) : dIn;
        acc_sum   = acc + ACC_W'(mag);
        handshake = (slot == FULL) && sadReady;
        complete  = dInValid && !clr && (cnt == LAST);
`ifdef SAD_ACCUM_PEAK_EN
        peak_max  = (mag > peak) ? mag : peak;
`endif
    end

    // Window accumulation plus the output slot and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            sadOut  <= '0;
            slot    <= EMPTY;
            ovfErr  <= 1'b0;
`ifdef SAD_ACCUM_PEAK_EN
            peak    <= '0;
            peakOut <= '0;
`endif
        end else begin
            if (clr) begin
                acc  <= '0;
                cnt  <= '0;
`ifdef SAD_ACCUM_PEAK_EN
                peak <= '0;
`endif
            end else if (dInValid) begin
                if (cnt == LAST) begin
                    acc  <= '0;
                    cnt  <= '0;
`ifdef SAD_ACCUM_PEAK_EN
                    peak <= '0;
`endif
                end else begin
                    acc  <= acc_sum;
                    cnt  <= cnt + CNT_ONE;
`ifdef SAD_ACCUM_PEAK_EN
                    peak <= peak_max;
`endif
                end
            end

            if (complete) begin
                if ((slot == EMPTY) || handshake) begin
                    sadOut  <= acc_sum;
`ifdef SAD_ACCUM_PEAK_EN
                    peakOut <= peak_max;
`endif
                    slot    <= FULL;
                end else begin
                    ovfErr <= 1'b1;
                end
            end else if (handshake) begin
                slot <= EMPTY;
            end
        end
    end

    assign sadValid = (slot == FULL);

endmodule
